// File: rtl/fusion_cfg_ctrl_if.sv
// Bundle between the CSR file / decode-fusion stage and the fusion
// configuration controller: mask write port, drain handshake, fusion events, counter readback.
interface fusion_cfg_ctrl_if #(
    parameter int NrPatterns = 8,
    parameter int CntWidth   = 32
);
    localparam int SelW = (NrPatterns > 1) ? $clog2(NrPatterns) : 1;

    logic                  cfg_we_i;
    logic [NrPatterns-1:0] cfg_wdata_i;
    logic                  cfg_ready_o;
    logic [NrPatterns-1:0] cfg_rdata_o;
    logic                  flush_req_o;
    logic                  pipe_idle_i;
    logic [NrPatterns-1:0] fuse_en_o;
    logic                  done_o;
    logic                  timeout_o;
    logic [NrPatterns-1:0] fuse_event_i;
    logic [SelW-1:0]       cnt_sel_i;
    logic                  cnt_clr_i;
    logic [CntWidth-1:0]   cnt_o;

    modport slave (
        input  cfg_we_i, cfg_wdata_i, pipe_idle_i, fuse_event_i, cnt_sel_i, cnt_clr_i,
        output cfg_ready_o, cfg_rdata_o, flush_req_o, fuse_en_o, done_o, timeout_o, cnt_o
    );

    modport master (
        output cfg_we_i, cfg_wdata_i, pipe_idle_i, fuse_event_i, cnt_sel_i, cnt_clr_i,
        input  cfg_ready_o, cfg_rdata_o, flush_req_o, fuse_en_o, done_o, timeout_o, cnt_o
    );
endinterface

// File: rtl/fusion_cfg_ctrl.sv
// Runtime macro-op fusion controller: drains the pipeline before switching the
// per-pattern enable mask, and keeps saturating per-pattern fusion event counters.
module fusion_cfg_ctrl #(
    parameter int                    NrPatterns   = 8,
    parameter int                    CntWidth     = 32,
    parameter logic [NrPatterns-1:0] ResetMask    = '1,
    parameter int                    DrainTimeout = 64,
    parameter bit                    FusionEn     = 1'b1
) (
    input logic              clk_i,
    input logic              rst_i,
    fusion_cfg_ctrl_if.slave bus
);
    localparam int SelW = (NrPatterns > 1) ? $clog2(NrPatterns) : 1;
    localparam int DcW  = $clog2(DrainTimeout);
    localparam logic [NrPatterns-1:0] EnGate = {NrPatterns{FusionEn}};
    localparam logic [NrPatterns-1:0] RstEn  = ResetMask & EnGate;
    localparam logic [CntWidth-1:0]   CntMax = '1;
    localparam logic [DcW-1:0]        DcLast = DcW'(DrainTimeout - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    state_e                state_r;
    state_e                state_s;
    logic [NrPatterns-1:0] pending_r;
    logic [NrPatterns-1:0] fuse_en_r;
    logic [DcW-1:0]        drain_cnt_r;
    logic                  done_r;
    logic                  timeout_r;
    logic                  flush_r;
    logic                  ready_r;
    logic                  load_pending_s;
    logic                  apply_s;
    logic                  abort_s;
    logic [CntWidth-1:0]   cnt_r [NrPatterns];
    logic [CntWidth-1:0]   cnt_rd_r;
    logic [CntWidth-1:0]   cnt_rd_s;
    logic [NrPatterns-1:0] sel_hit_s;

    // Next-state logic; an idle pipeline takes priority over the drain timeout.
    always_comb begin
        state_s        = state_r;
        load_pending_s = 1'b0;
        apply_s        = 1'b0;
        abort_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cfg_we_i && (bus.cfg_wdata_i != fuse_en_r)) begin
                    load_pending_s = 1'b1;
                    state_s        = ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.pipe_idle_i) begin
                    apply_s = 1'b1;
                    state_s = ST_APPLY;
                end else if (drain_cnt_r == DcLast) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_APPLY: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // FSM state, pending mask, active mask and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            pending_r   <= '0;
            fuse_en_r   <= RstEn;
            drain_cnt_r <= '0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            flush_r     <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            state_r     <= state_s;
            if (load_pending_s) begin
                pending_r <= bus.cfg_wdata_i;
            end else if (abort_s) begin
                pending_r <= '0;
            end
            if (apply_s) begin
                fuse_en_r <= pending_r & EnGate;
            end
            drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + DcW'(1) : '0;
            done_r      <= apply_s;
            timeout_r   <= abort_s;
            flush_r     <= (state_s == ST_DRAIN);
            ready_r     <= (state_s == ST_IDLE);
        end
    end

    // Select decode; an out-of-range select matches no counter and reads 0.
    always_comb begin
        sel_hit_s = '0;
        cnt_rd_s  = '0;
        for (int k = 0; k < NrPatterns; k++) begin
            sel_hit_s[k] = (bus.cnt_sel_i == SelW'(k));
            cnt_rd_s     = cnt_rd_s | (sel_hit_s[k] ? cnt_r[k] : {CntWidth{1'b0}});
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrPatterns; k++) begin
            if (rst_i) begin
                cnt_r[k] <= '0;
            end else if (bus.cnt_clr_i && sel_hit_s[k]) begin
                cnt_r[k] <= '0;
            end else if (bus.fuse_event_i[k] && fuse_en_r[k] && EnGate[k] &&
                         (cnt_r[k] != CntMax)) begin
                cnt_r[k] <= cnt_r[k] + CntWidth'(1);
            end
        end
    end

    // Registered readback of the selected counter (pre-increment value).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_rd_r <= '0;
        end else begin
            cnt_rd_r <= cnt_rd_s;
        end
    end

    assign bus.cfg_ready_o = ready_r;
    assign bus.cfg_rdata_o = fuse_en_r;
    assign bus.fuse_en_o   = fuse_en_r;
    assign bus.flush_req_o = flush_r;
    assign bus.done_o      = done_r;
    assign bus.timeout_o   = timeout_r;
    assign bus.cnt_o       = cnt_rd_r;

endmodule

// File: tb/tb_fusion_cfg_ctrl.sv
// Directed, table-driven bench for fusion_cfg_ctrl: a default instance (8 patterns,
// 32-bit counters, timeout 64) and a small one (6 patterns, 4-bit counters, timeout 4).
module tb_fusion_cfg_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst2;

    fusion_cfg_ctrl_if #(.NrPatterns(8), .CntWidth(32)) bus1 ();
    fusion_cfg_ctrl_if #(.NrPatterns(6), .CntWidth(4))  bus2 ();

    fusion_cfg_ctrl #(
        .NrPatterns(8), .CntWidth(32), .ResetMask(8'hFF), .DrainTimeout(64), .FusionEn(1'b1)
    ) u_dut (
        .clk_i(clk), .rst_i(rst1), .bus(bus1)
    );

    fusion_cfg_ctrl #(
        .NrPatterns(6), .CntWidth(4), .ResetMask(6'h3F), .DrainTimeout(4), .FusionEn(1'b1)
    ) u_dut2 (
        .clk_i(clk), .rst_i(rst2), .bus(bus2)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [7:0]  wdata;
        logic        idle;
        logic [7:0]  ev;
        logic [2:0]  sel;
        logic        clr;
        logic        e_ready;
        logic        e_flush;
        logic [7:0]  e_en;
        logic        e_done;
        logic        e_to;
        logic [31:0] e_cnt;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic we, input logic [7:0] wdata,
                                input logic idle, input logic [7:0] ev, input logic [2:0] sel,
                                input logic clr, input logic e_ready, input logic e_flush,
                                input logic [7:0] e_en, input logic e_done, input logic e_to,
                                input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.we = we; v.wdata = wdata; v.idle = idle; v.ev = ev; v.sel = sel;
        v.clr = clr; v.e_ready = e_ready; v.e_flush = e_flush; v.e_en = e_en;
        v.e_done = e_done; v.e_to = e_to; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Inputs are driven for one cycle; expectations describe the following cycle.
    task automatic run1(input vec_t v);
        @(negedge clk);
        rst1 = v.rst; bus1.cfg_we_i = v.we; bus1.cfg_wdata_i = v.wdata;
        bus1.pipe_idle_i = v.idle; bus1.fuse_event_i = v.ev;
        bus1.cnt_sel_i = v.sel; bus1.cnt_clr_i = v.clr;
        @(posedge clk);
        #1;
        cmp("d1_ready",   n_vec, 64'(bus1.cfg_ready_o), 64'(v.e_ready));
        cmp("d1_flush",   n_vec, 64'(bus1.flush_req_o), 64'(v.e_flush));
        cmp("d1_fuse_en", n_vec, 64'(bus1.fuse_en_o),   64'(v.e_en));
        cmp("d1_rdata",   n_vec, 64'(bus1.cfg_rdata_o), 64'(v.e_en));
        cmp("d1_done",    n_vec, 64'(bus1.done_o),      64'(v.e_done));
        cmp("d1_timeout", n_vec, 64'(bus1.timeout_o),   64'(v.e_to));
        cmp("d1_cnt",     n_vec, 64'(bus1.cnt_o),       64'(v.e_cnt));
        n_vec++;
    endtask

    task automatic run2(input vec_t v);
        @(negedge clk);
        rst2 = v.rst; bus2.cfg_we_i = v.we; bus2.cfg_wdata_i = v.wdata[5:0];
        bus2.pipe_idle_i = v.idle; bus2.fuse_event_i = v.ev[5:0];
        bus2.cnt_sel_i = v.sel; bus2.cnt_clr_i = v.clr;
        @(posedge clk);
        #1;
        cmp("d2_ready",   n_vec, 64'(bus2.cfg_ready_o), 64'(v.e_ready));
        cmp("d2_flush",   n_vec, 64'(bus2.flush_req_o), 64'(v.e_flush));
        cmp("d2_fuse_en", n_vec, 64'(bus2.fuse_en_o),   64'(v.e_en[5:0]));
        cmp("d2_done",    n_vec, 64'(bus2.done_o),      64'(v.e_done));
        cmp("d2_timeout", n_vec, 64'(bus2.timeout_o),   64'(v.e_to));
        cmp("d2_cnt",     n_vec, 64'(bus2.cnt_o),       64'(v.e_cnt[3:0]));
        n_vec++;
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        bus1.cfg_we_i = 1'b0; bus1.cfg_wdata_i = 8'h00; bus1.pipe_idle_i = 1'b0;
        bus1.fuse_event_i = 8'h00; bus1.cnt_sel_i = 3'd0; bus1.cnt_clr_i = 1'b0;
        bus2.cfg_we_i = 1'b0; bus2.cfg_wdata_i = 6'h00; bus2.pipe_idle_i = 1'b0;
        bus2.fuse_event_i = 6'h00; bus2.cnt_sel_i = 3'd0; bus2.cnt_clr_i = 1'b0;

        // reset, then write 8'h0F with idle first seen in cycle 4 (second write ignored)
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b0,8'h00,3'd0,1'b0, 1'b1,1'b0,8'hFF,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b1,1'b0,8'h00,1'b0,8'h00,3'd0,1'b0, 1'b1,1'b0,8'hFF,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b1,8'h0F,1'b0,8'h00,3'd0,1'b0, 1'b0,1'b1,8'hFF,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd0,1'b0, 1'b0,1'b1,8'hFF,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd0,1'b0, 1'b0,1'b1,8'hFF,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b1,8'hAA,1'b0,8'h00,3'd0,1'b0, 1'b0,1'b1,8'hFF,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b1,8'h00,3'd0,1'b0, 1'b0,1'b0,8'h0F,1'b1,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd0,1'b0, 1'b1,1'b0,8'h0F,1'b0,1'b0,32'd0));
        // write equal to the active mask is a no-op
        tbl.push_back(mk(1'b0,1'b1,8'h0F,1'b0,8'h00,3'd0,1'b0, 1'b1,1'b0,8'h0F,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd0,1'b0, 1'b1,1'b0,8'h0F,1'b0,1'b0,32'd0));
        // minimum latency change to 8'h04; a write during APPLY is ignored
        tbl.push_back(mk(1'b0,1'b1,8'h04,1'b1,8'h00,3'd0,1'b0, 1'b0,1'b1,8'h0F,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b1,8'h00,3'd0,1'b0, 1'b0,1'b0,8'h04,1'b1,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b1,8'h55,1'b0,8'h00,3'd0,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd0));
        // 5 events on pattern 2, 3 on the disabled pattern 6
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h44,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h44,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd1));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h44,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd2));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h04,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd3));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h04,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd4));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd5));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd6,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd0));
        // clear coinciding with an event
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h04,3'd2,1'b1, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd5));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h04,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd0));
        tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd1));

        for (int i = 0; i < tbl.size(); i++) begin
            run1(tbl[i]);
        end

        // timeout: write 8'h00 at cycle 0, idle never seen
        run1(mk(1'b0,1'b1,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b0,1'b1,8'h04,1'b0,1'b0,32'd1));
        for (int c = 1; c < 64; c++) begin
            run1(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b0,1'b1,8'h04,1'b0,1'b0,32'd1));
        end
        run1(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b1,32'd1));
        run1(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h04,1'b0,1'b0,32'd1));

        // reset asserted in DRAIN cycle 3
        run1(mk(1'b0,1'b1,8'h0F,1'b0,8'h00,3'd2,1'b0, 1'b0,1'b1,8'h04,1'b0,1'b0,32'd1));
        run1(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b0,1'b1,8'h04,1'b0,1'b0,32'd1));
        run1(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b0,1'b1,8'h04,1'b0,1'b0,32'd1));
        run1(mk(1'b1,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'hFF,1'b0,1'b0,32'd0));
        run1(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'hFF,1'b0,1'b0,32'd0));

        // small instance: saturation at 15 after 20 events
        run2(mk(1'b1,1'b0,8'h00,1'b0,8'h00,3'd0,1'b0, 1'b1,1'b0,8'h3F,1'b0,1'b0,32'd0));
        for (int i = 0; i < 20; i++) begin
            run2(mk(1'b0,1'b0,8'h00,1'b0,8'h04,3'd2,1'b0, 1'b1,1'b0,8'h3F,1'b0,1'b0,
                    (i < 15) ? 32'(i) : 32'd15));
        end
        run2(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h3F,1'b0,1'b0,32'd15));
        // out-of-range select reads 0 and its clear touches nothing
        run2(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd7,1'b0, 1'b1,1'b0,8'h3F,1'b0,1'b0,32'd0));
        run2(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd6,1'b1, 1'b1,1'b0,8'h3F,1'b0,1'b0,32'd0));
        run2(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h3F,1'b0,1'b0,32'd15));
        // idle in the last DRAIN cycle wins over the timeout
        run2(mk(1'b0,1'b1,8'h05,1'b0,8'h00,3'd2,1'b0, 1'b0,1'b1,8'h3F,1'b0,1'b0,32'd15));
        for (int c = 1; c < 4; c++) begin
            run2(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b0,1'b1,8'h3F,1'b0,1'b0,32'd15));
        end
        run2(mk(1'b0,1'b0,8'h00,1'b1,8'h00,3'd2,1'b0, 1'b0,1'b0,8'h05,1'b1,1'b0,32'd15));
        run2(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h05,1'b0,1'b0,32'd15));
        // timeout after exactly 4 DRAIN cycles
        run2(mk(1'b0,1'b1,8'h3F,1'b0,8'h00,3'd2,1'b0, 1'b0,1'b1,8'h05,1'b0,1'b0,32'd15));
        for (int c = 1; c < 4; c++) begin
            run2(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b0,1'b1,8'h05,1'b0,1'b0,32'd15));
        end
        run2(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h05,1'b0,1'b1,32'd15));
        run2(mk(1'b0,1'b0,8'h00,1'b0,8'h00,3'd2,1'b0, 1'b1,1'b0,8'h05,1'b0,1'b0,32'd15));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
